// File: rtl/fetch_stage.sv
// fetch_stage: PC register, held icache request and 2-entry instruction FIFO toward decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [31:0]          icache_addr,
    output logic                 icache_valid,
    input  logic                 icache_hit,
    input  logic [WORD_SIZE-1:0] icache_data,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_instr,
    output logic [31:0]          out_pc,
    output logic [31:0]          miss_cycles
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
    state_t               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [WORD_SIZE-1:0] instr_q [2];
    logic [31:0]          pcs_q [2];
    logic                 rd_q, wr_q;
    logic [1:0]           count_q, count_d;
    logic [31:0]          miss_q;
    logic                 push, pop;
    // a redirect swallows both the hit and the pop of its cycle
    assign push = (state_q == REQ) && icache_hit && !redirect_valid;
    assign pop  = (count_q != 2'd0) && out_ready && !redirect_valid;
    assign count_d = redirect_valid ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    // next state and next PC; redirect has priority over everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redirect_valid) begin
            state_d = REQ;
            pc_d    = {redirect_pc[31:2], 2'b00};
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (icache_hit) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = (count_d == 2'd2) ? HOLD : REQ;
                    end
                end
                HOLD:    state_d = pop ? REQ : HOLD;
                default: state_d = IDLE;
            endcase
        end
    end
    // state, PC, FIFO storage/pointers and miss counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q[0] <= '0;
            instr_q[1] <= '0;
            pcs_q[0]   <= '0;
            pcs_q[1]   <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            count_q    <= 2'd0;
            miss_q     <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            if (state_q == REQ && !icache_hit) miss_q <= miss_q + 32'd1;
            if (redirect_valid) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end else begin
                if (push) begin
                    instr_q[wr_q] <= icache_data;
                    pcs_q[wr_q]   <= pc_q;
                    wr_q          <= ~wr_q;
                end
                if (pop) rd_q <= ~rd_q;
            end
        end
    end
    assign icache_addr  = pc_q;
    assign icache_valid = (state_q == REQ);
    assign out_valid    = (count_q != 2'd0);
    assign out_instr    = instr_q[rd_q];
    assign out_pc       = pcs_q[rd_q];
    assign miss_cycles  = miss_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table for fetch_stage plus an in-order scoreboard on the decode side
module tb_fetch_stage;
    logic        clk, reset, icache_valid, icache_hit, redirect_valid, out_valid, out_ready;
    logic [31:0] icache_addr, icache_data, redirect_pc, out_instr, out_pc, miss_cycles;
    int checks = 0;
    int failures = 0;

    fetch_stage #(.RESET_PC(32'h100), .WORD_SIZE(32)) dut (
        .clk(clk), .reset(reset), .icache_addr(icache_addr), .icache_valid(icache_valid),
        .icache_hit(icache_hit), .icache_data(icache_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .miss_cycles(miss_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, hit, redir, ready;
        logic [31:0] data, rpc;
        logic        ev;
        logic [31:0] ea;
        logic        eo, co;
        logic [31:0] epc, eins, emiss;
    } vec_t;

    typedef struct {
        logic [31:0] pc, ins;
    } ent_t;

    vec_t        vecs[$];
    ent_t        sbq[$];
    ent_t        e;
    logic [31:0] exp_pc;

    function automatic vec_t mk(input logic rst, hit, input logic [31:0] data, input logic redir,
                                input logic [31:0] rpc, input logic ready, input logic ev,
                                input logic [31:0] ea, input logic eo, co,
                                input logic [31:0] epc, eins, emiss);
        vec_t v;
        v.rst = rst; v.hit = hit; v.data = data; v.redir = redir; v.rpc = rpc; v.ready = ready;
        v.ev = ev; v.ea = ea; v.eo = eo; v.co = co; v.epc = epc; v.eins = eins; v.emiss = emiss;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // decode-side scoreboard: entries enter on each accepted hit, leave on each pop
    always @(negedge clk) begin
        if (reset) begin
            sbq.delete();
            exp_pc = 32'h100;
        end else if (redirect_valid) begin
            sbq.delete();
            exp_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_pop_empty: got pc %h expected no entry", out_pc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", out_instr, e.ins);
                end
            end
            if (icache_valid && icache_hit) begin
                chk("sb_fetch_addr", icache_addr, exp_pc);
                e.pc = exp_pc;
                e.ins = icache_data;
                sbq.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    initial begin
        reset = 1'b1; icache_hit = 1'b0; icache_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 0, 1, 32'h104, 1, 1, 32'h100, 32'hDEADBEEF, 3));
        vecs.push_back(mk(0, 1, 32'hA0, 0, 0, 1, 1, 32'h108, 1, 1, 32'h104, 32'hA0, 3));
        vecs.push_back(mk(0, 1, 32'hA1, 0, 0, 0, 0, 32'h10C, 1, 1, 32'h104, 32'hA0, 3));
        vecs.push_back(mk(0, 1, 32'h55, 0, 0, 0, 0, 32'h10C, 1, 1, 32'h104, 32'hA0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h10C, 1, 1, 32'h108, 32'hA1, 3));
        vecs.push_back(mk(0, 1, 32'hB0, 0, 0, 0, 0, 32'h110, 1, 1, 32'h108, 32'hA1, 3));
        vecs.push_back(mk(0, 1, 32'hBAD, 1, 32'h2003, 1, 1, 32'h2000, 0, 0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 4));
        vecs.push_back(mk(0, 1, 32'hC0, 0, 0, 0, 1, 32'h2004, 1, 1, 32'h2000, 32'hC0, 4));
        vecs.push_back(mk(0, 1, 32'hBAD2, 1, 0, 0, 1, 32'h0, 0, 0, 0, 0, 4));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 32'h1000 + 32'(i), 0, 0, 1, 1, 32'(4 * (i + 1)), 1, 1,
                              32'(4 * i), 32'h1000 + 32'(i), 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 32'h20, 0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 1, 32'hBAD3, 1, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFC, 0, 0, 0, 0, 5));
        vecs.push_back(mk(0, 1, 32'hE0, 0, 0, 0, 1, 32'h0, 1, 1, 32'hFFFFFFFC, 32'hE0, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            icache_hit = vecs[i].hit;
            icache_data = vecs[i].data;
            redirect_valid = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            out_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d icache_valid", i), {31'b0, icache_valid}, {31'b0, vecs[i].ev});
            chk($sformatf("row%0d icache_addr", i), icache_addr, vecs[i].ea);
            chk($sformatf("row%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eo});
            chk($sformatf("row%0d miss_cycles", i), miss_cycles, vecs[i].emiss);
            if (vecs[i].co) begin
                chk($sformatf("row%0d out_pc", i), out_pc, vecs[i].epc);
                chk($sformatf("row%0d out_instr", i), out_instr, vecs[i].eins);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
